// File: rtl/sram_master.sv
// -----------------------------------------------------------------------------
// sram_master
//
// Initiator-side controller for the 1024x32 on-chip SRAM port, serving one
// client (weight/activation loader). A burst request is accepted on a
// valid/ready front end. The burst is then played out one SRAM beat at a time,
// and each beat is handshaken on the SRAM status code.
//
// Ports
//   clk, rst           system clock (rising edge), asynchronous active-high reset
//   req_valid/ready    burst request handshake; ready only when idle and out of reset
//   req_write          1 = write burst, 0 = read burst
//   req_addr           start word address (wraps mod 2^ADDR_W)
//   req_len            beats minus one (0..15)
//   wr_valid/ready     write beat data handshake; ready only while waiting for data
//   wr_data            write beat data
//   rd_valid           one-cycle pulse per returned read beat (no backpressure)
//   rd_data            read beat data, held until the next rd_valid
//   rd_last            marks the final rd_valid of a burst
//   done               one-cycle pulse, burst completed without error
//   err                one-cycle pulse, burst aborted (SRAM error or timeout)
//   busy               controller is not idle
//   sram_addr          SRAM word address
//   sram_read_en       SRAM read enable
//   sram_write_en      SRAM write enable
//   sram_write_data    SRAM write data
//   sram_read_data     SRAM read data, valid while sram_state = ACCESS
//   sram_state         SRAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
// -----------------------------------------------------------------------------
module sram_master #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read_en,
    output logic              sram_write_en,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data,
    input  logic [1:0]        sram_state
);

    // Controller states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_WD = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    // SRAM status codes (01 = BUSY needs no decode: it simply means "keep waiting")
    localparam logic [1:0] SRAM_FREE   = 2'b00;
    localparam logic [1:0] SRAM_ACCESS = 2'b10;
    localparam logic [1:0] SRAM_ERROR  = 2'b11;

    // The counter starts at 0 on the first cycle of ISSUE/GAP, so the abort
    // fires on the posedge that ends the TIMEOUT-th cycle in that state.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        beat_cnt;
    logic [3:0]        len_q;
    logic              write_q;
    logic [7:0]        tmo_cnt;

    logic              accept;
    logic              wd_take;
    logic              beat_ok;
    logic              abort;
    logic              gap_exit;
    logic              advance;
    logic              launch;
    logic              final_beat;
    logic [ADDR_W-1:0] launch_addr;

    // Word address increment; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    function automatic logic tmo_expired(input logic [7:0] cnt);
        return cnt == TMO_LAST;
    endfunction

    assign req_ready  = (state == S_IDLE) && !rst;
    assign wr_ready   = (state == S_WAIT_WD);
    assign busy       = (state != S_IDLE);
    assign final_beat = (beat_cnt == len_q);

    // Control strobes and next-state decode
    always_comb begin
        accept      = (state == S_IDLE) && req_valid && req_ready;
        wd_take     = (state == S_WAIT_WD) && wr_valid;
        // ACCESS takes priority over a coincident timeout.
        beat_ok     = (state == S_ISSUE) && (sram_state == SRAM_ACCESS);
        gap_exit    = (state == S_GAP) && (sram_state == SRAM_FREE);
        abort       = 1'b0;
        if ((state == S_ISSUE) && !beat_ok)
            abort = (sram_state == SRAM_ERROR) || tmo_expired(tmo_cnt);
        if ((state == S_GAP) && !gap_exit)
            abort = (sram_state == SRAM_ERROR) || tmo_expired(tmo_cnt);
        advance     = gap_exit && !final_beat;
        // Any transition into ISSUE raises exactly one enable.
        launch      = (accept && !req_write) || wd_take || (advance && !write_q);
        launch_addr = cur_addr;
        if (accept)
            launch_addr = req_addr;
        else if (advance)
            launch_addr = addr_inc(cur_addr);

        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = req_write ? S_WAIT_WD : S_ISSUE;
            end
            S_WAIT_WD: begin
                if (wd_take)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (beat_ok)
                    state_nxt = S_GAP;
                else if (abort)
                    state_nxt = S_IDLE;
            end
            S_GAP: begin
                if (gap_exit) begin
                    if (final_beat)
                        state_nxt = S_IDLE;
                    else
                        state_nxt = write_q ? S_WAIT_WD : S_ISSUE;
                end else if (abort) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered state, SRAM drive and client-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cur_addr        <= '0;
            beat_cnt        <= '0;
            len_q           <= '0;
            write_q         <= 1'b0;
            tmo_cnt         <= '0;
            sram_addr       <= '0;
            sram_read_en    <= 1'b0;
            sram_write_en   <= 1'b0;
            sram_write_data <= '0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            rd_last         <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= beat_ok && !write_q;
            rd_last  <= beat_ok && !write_q && final_beat;
            done     <= gap_exit && final_beat;
            err      <= abort;

            if (accept) begin
                cur_addr <= req_addr;
                len_q    <= req_len;
                write_q  <= req_write;
                beat_cnt <= '0;
            end else if (advance) begin
                cur_addr <= addr_inc(cur_addr);
                beat_cnt <= beat_cnt + 4'd1;
            end

            if (wd_take)
                sram_write_data <= wr_data;

            if (beat_ok && !write_q)
                rd_data <= sram_read_data;

            // Address and enables only change on ISSUE entry/exit, so both are
            // stable for the whole access.
            if (launch) begin
                sram_addr     <= launch_addr;
                sram_read_en  <= !wd_take;
                sram_write_en <= wd_take;
            end else if (beat_ok || abort) begin
                sram_read_en  <= 1'b0;
                sram_write_en <= 1'b0;
            end

            if (launch || beat_ok)
                tmo_cnt <= '0;
            else if ((state == S_ISSUE) || (state == S_GAP))
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

endmodule

// File: doc/sram_master.md
Name: sram_master

Overview:
- Initiator-side controller that drives the 1024x32 on-chip SRAM port on behalf of one client (weight/activation loader).
- Accepts burst read/write requests on a valid/ready front end and sequences one SRAM beat at a time, handshaking on the SRAM status code.
- Returns read beats on a registered stream, and signals burst completion or error with single-cycle pulses.

Parameters:
- TIMEOUT, 64, max cycles an enable is held (or a gap waits) before abort; 2..255
- ADDR_W, 10, SRAM word address width; wraps mod 2^ADDR_W
- DATA_W, 32, SRAM data width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  burst request valid
- req_ready  out  1  high only in IDLE with rst low
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start word address
- req_len  in  4  beats minus 1 (0 = 1 beat, 15 = 16 beats)
- wr_valid  in  1  write beat data valid
- wr_ready  out  1  high only in WAIT_WD
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  one-cycle pulse per read beat, no backpressure
- rd_data  out  DATA_W  read beat data, held until next rd_valid
- rd_last  out  1  qualifies final rd_valid of a burst
- done  out  1  one-cycle pulse, burst completed without error
- err  out  1  one-cycle pulse, burst aborted
- busy  out  1  state != IDLE
- sram_addr  out  ADDR_W  SRAM word address
- sram_read_en  out  1  SRAM read enable
- sram_write_en  out  1  SRAM write enable
- sram_write_data  out  DATA_W  SRAM write data
- sram_read_data  in  DATA_W  SRAM read data, valid when sram_state = ACCESS
- sram_state  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR

Behaviour:
- All outputs are registered except req_ready, wr_ready and busy, which decode state.
- Reset (asynchronous, immediate):
  - state = IDLE.
  - sram_addr, sram_write_data, rd_data, beat count and timeout count = 0.
  - All enables and pulses = 0.
  - Reset mid-burst drops enables at once; no done/err is produced.
- States: IDLE, WAIT_WD, ISSUE, GAP.
- IDLE:
  - On req_valid & req_ready, latch req_addr to cur_addr, and latch req_len and req_write; clear beat count.
  - Next state is WAIT_WD for a write, ISSUE for a read.
- WAIT_WD:
  - On wr_valid, latch wr_data into sram_write_data, then go to ISSUE.
  - No timeout applies here.
- ISSUE:
  - Exactly one of sram_read_en/sram_write_en is 1; they are never both 1.
  - sram_addr = cur_addr and sram_write_data are held stable for the whole state.
  - The timeout counter clears on entry and increments each cycle.
- Beat completion: sram_state = ACCESS sampled at a posedge in ISSUE.
  - Read: sram_read_data is captured into rd_data; rd_valid = 1 in the next cycle; rd_last = 1 if this is the final beat.
  - Enables go low in the next cycle; next state is GAP.
- GAP:
  - Enables stay low for at least one cycle; exit requires sram_state = FREE.
  - Not final beat: cur_addr = cur_addr+1 mod 1024 (1023 -> 0), beat count +1; next state WAIT_WD (write) or ISSUE (read).
  - Final beat: done = 1 for one cycle; next state IDLE.
- Abort, in ISSUE or GAP:
  - Trigger: sram_state = ERROR sampled, or the timeout counter reaches TIMEOUT.
  - Enables drop next cycle; err = 1 for one cycle; next state IDLE.
  - Remaining beats are discarded; no rd_valid for the aborted beat; done is not asserted.
- ERROR and ACCESS cannot coincide; if both the timeout and ACCESS occur in the same cycle, ACCESS wins.
- Minimum cost is 2 cycles per beat (ISSUE + GAP) plus the SRAM's response latency.

Test Plan:
- Single write, then single read:
  - Stimulus: write len 0, addr 300, data FFFF_FFFF; SRAM model gives ACCESS on the 3rd enable cycle; then read addr 300.
  - Response: sram_write_en high 3 cycles, done pulse; rd_valid once with rd_data = FFFF_FFFF, rd_last = 1, done one cycle after rd_valid.
- Read burst across wrap:
  - Stimulus: len 3 from addr 1022, memory preloaded with word = address.
  - Response: sram_addr sequence 1022, 1023, 0, 1; rd_data 3FE, 3FF, 0, 1; rd_last only on the 4th beat; enables low at least 1 cycle between beats.
- Write burst with stalled data:
  - Stimulus: len 1, wr_valid held low 5 cycles before each beat.
  - Response: wr_ready high during stalls, no sram_write_en until data is accepted, done after the 2nd beat.
- SRAM error:
  - Stimulus: read len 2; sram_state = ERROR during the 2nd beat.
  - Response: 1 rd_valid, err pulse, no done, enables low next cycle, req_ready high afterwards.
- Timeout:
  - Stimulus: TIMEOUT = 8; SRAM model stuck at BUSY.
  - Response: enable high exactly 8 cycles, then err pulse and return to IDLE.
- Reset mid-burst:
  - Stimulus: rst asserted asynchronously during ISSUE of a write.
  - Response: sram_write_en is 0 before the next clock edge; no done/err; after rst is released, a new request is accepted normally.
